// File: rtl/io_tx_buffer.sv
//======================================================================
// Module      : io_tx_buffer
// Description : I/O window decoder with a TX byte FIFO feeding the UART,
//               cycle-counter reads and an orderly program-stop drain.
//               Optional macro IO_TX_STAT_EN adds a sent-byte counter.
// Revision    : 1.0 - initial release
//======================================================================
`default_nettype none

module io_tx_buffer #(
    parameter int DEPTH_LOG2  = 4,
    parameter int FULL_MARGIN = 4
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic [31:0] mem_a,
    input  logic [7:0]  mem_dout,
    input  logic        mem_wr,
    output logic [7:0]  io_din,
    output logic        io_buffer_full,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        program_done,
    output logic        overflow
);

    localparam int                DEPTH         = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] C_DEPTH     = (DEPTH_LOG2+1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] C_FULL_THRESH = (DEPTH_LOG2+1)'(DEPTH - FULL_MARGIN);

    typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_TAIL, ST_DONE} state_t;

    state_t              r_state;
    logic [7:0]          r_mem [DEPTH];
    logic [DEPTH_LOG2:0] r_wptr;
    logic [DEPTH_LOG2:0] r_rptr;
    logic [31:0]         r_cycle;
    logic [31:8]         r_snap;

    logic [DEPTH_LOG2:0] w_count;
    logic [DEPTH_LOG2:0] w_count_nxt;
    logic                w_empty;
    logic                w_full;
    logic                w_io;
    logic                w_fifo_out;
    logic                w_pop;
    logic                w_out_wr;
    logic                w_push;
    logic                w_drop;
    logic                w_stop;
    logic                w_unused_bits;

    assign w_count    = r_wptr - r_rptr;
    assign w_empty    = (w_count == '0);
    assign w_full     = (w_count == C_DEPTH);
    assign w_io       = rdy_in && (mem_a[17:16] == 2'b11);

    // FIFO head is only presented while running or draining; TAIL sends the 0x00 terminator.
    assign w_fifo_out = ((r_state == ST_RUN) || (r_state == ST_DRAIN)) && !w_empty;
    assign tx_valid   = w_fifo_out || (r_state == ST_TAIL);
    assign tx_data    = w_fifo_out ? r_mem[r_rptr[DEPTH_LOG2-1:0]] : 8'h00;

    assign w_pop      = w_fifo_out && tx_ready;
    assign w_out_wr   = w_io && mem_wr && (mem_a[2:0] == 3'd0) && (r_state == ST_RUN)
                        && (mem_dout != 8'h00);
    assign w_push     = w_out_wr && (!w_full || w_pop);
    assign w_drop     = w_out_wr && w_full && !w_pop;
    assign w_stop     = w_io && mem_wr && (mem_a[2:0] == 3'd4) && (r_state == ST_RUN);
    assign w_count_nxt = w_count + {{DEPTH_LOG2{1'b0}}, w_push} - {{DEPTH_LOG2{1'b0}}, w_pop};

    assign w_unused_bits = ^{mem_a[31:18], mem_a[15:3]};

    always_ff @(posedge clk_in) begin
        if (w_push) begin
            r_mem[r_wptr[DEPTH_LOG2-1:0]] <= mem_dout;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state        <= ST_RUN;
            r_wptr         <= '0;
            r_rptr         <= '0;
            io_buffer_full <= 1'b0;
            program_done   <= 1'b0;
            overflow       <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            if (w_drop) overflow <= 1'b1;
            // Only the stop write leaves RUN, so it alone forces backpressure on.
            io_buffer_full <= (r_state != ST_RUN) || w_stop || (w_count_nxt >= C_FULL_THRESH);
            case (r_state)
                ST_RUN: begin
                    if (w_stop) r_state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (w_empty) r_state <= ST_TAIL;
                end
                ST_TAIL: begin
                    if (tx_ready) begin
                        r_state      <= ST_DONE;
                        program_done <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_DONE;
                end
            endcase
        end
    end

`ifdef IO_TX_STAT_EN
    logic [31:0] r_sent;
    logic [31:8] r_sent_snap;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_sent <= '0;
        end else if (w_pop) begin
            r_sent <= r_sent + 32'd1;
        end
    end
`endif

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_cycle <= '0;
            r_snap  <= '0;
            io_din  <= 8'h00;
`ifdef IO_TX_STAT_EN
            r_sent_snap <= '0;
`endif
        end else begin
            r_cycle <= r_cycle + 32'd1;
            if (w_io && !mem_wr) begin
`ifdef IO_TX_STAT_EN
                if (mem_a[3:2] == 2'b10) begin
                    case (mem_a[1:0])
                        2'd0: begin
                            r_sent_snap <= r_sent[31:8];
                            io_din      <= r_sent[7:0];
                        end
                        2'd1:    io_din <= r_sent_snap[15:8];
                        2'd2:    io_din <= r_sent_snap[23:16];
                        default: io_din <= r_sent_snap[31:24];
                    endcase
                end else
`endif
                begin
                    case (mem_a[2:0])
                        3'd4: begin
                            r_snap <= r_cycle[31:8];
                            io_din <= r_cycle[7:0];
                        end
                        3'd5:    io_din <= r_snap[15:8];
                        3'd6:    io_din <= r_snap[23:16];
                        3'd7:    io_din <= r_snap[31:24];
                        default: io_din <= 8'h00;
                    endcase
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: doc/io_tx_buffer.md
Name: io_tx_buffer

Overview:
- Sits directly downstream of the cpu top's external memory bus (`mem_a`/`mem_dout`/`mem_wr`) and directly upstream of the UART transmitter.
- Decodes the I/O window (`mem_a[17:16]==2'b11`) and buffers output bytes written to 0x30000 in a FIFO.
- Drives the cpu's `io_buffer_full` backpressure input.
- Serves the 0x30004 cycle-counter read and handles the 0x30004 program-stop write with an orderly drain.

Parameters:
- DEPTH_LOG2, 4, log2 of FIFO depth (16 entries).
- FULL_MARGIN, 4, free entries still available when `io_buffer_full` asserts; covers cpu pipeline stores already in flight.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  synchronous, active-high reset
- rdy_in  input  1  bus qualifier; when low, cpu-side accesses are ignored
- mem_a  input  32  cpu address bus (only [17:0] decoded)
- mem_dout  input  8  cpu write data
- mem_wr  input  1  1 = write, 0 = read
- io_din  output  8  read data to cpu, valid the cycle after the read
- io_buffer_full  output  1  backpressure to cpu
- tx_data  output  8  byte to UART
- tx_valid  output  1  tx_data valid
- tx_ready  input  1  UART accepts byte when tx_valid & tx_ready
- program_done  output  1  sticky; stop write processed and FIFO drained
- overflow  output  1  sticky; a byte was dropped because the FIFO was full

Behaviour:
- Reset (rst_in=1 at a clock edge), regardless of state:
  - FIFO emptied; cycle counter = 0; state = RUN.
  - Outputs: `io_din`=0, `tx_valid`=0, `tx_data`=0, `io_buffer_full`=0, `program_done`=0, `overflow`=0.
- Access decode: `io = rdy_in & (mem_a[17:16]==2'b11)`. Non-I/O addresses are ignored entirely.
- Output write (`io & mem_wr & mem_a[2:0]==0`, state RUN):
  - `mem_dout==8'h00`: ignored.
  - Otherwise pushed into the FIFO.
  - FIFO full: byte dropped, `overflow` set.
  - Push and pop in the same cycle on a full FIFO: the push is accepted.
- FIFO structure:
  - Circular buffer; pointers are DEPTH_LOG2+1 bits and wrap naturally.
  - count = wptr − rptr, modulo 2^(DEPTH_LOG2+1).
- `io_buffer_full`: registered; equals (count ≥ 2^DEPTH_LOG2 − FULL_MARGIN), computed from the post-update count.
- TX side:
  - `tx_data` = FIFO head; `tx_valid` = FIFO non-empty (combinational from registered pointers).
  - Pop occurs when `tx_valid & tx_ready`.
- Cycle counter:
  - 32-bit, increments every cycle not in reset; wraps 0xFFFFFFFF→0.
  - Counts independently of `rdy_in`.
- Counter read (`io & !mem_wr`), `io_din` is registered (1-cycle latency):
  - `mem_a[2:0]==4`: snapshot ← counter; `io_din` ← counter[7:0].
  - `mem_a[2:0]==5/6/7`: `io_din` ← snapshot byte 1/2/3.
  - Any other I/O read: `io_din` ← 8'h00.
  - Non-I/O cycles: `io_din` holds its value.
- Stop FSM (states RUN, DRAIN, TAIL, DONE):
  - RUN: write to 0x30004 → DRAIN. A same-cycle 0x30000 write is impossible (single bus).
  - DRAIN: further writes are ignored; wait until the FIFO is empty → TAIL.
  - TAIL: drive `tx_data`=8'h00, `tx_valid`=1; on `tx_ready` → DONE.
  - DONE: `program_done`=1; `tx_valid`=0; all writes ignored; reads still served.
  - Only reset leaves DONE.
- `io_buffer_full` remains asserted in DRAIN, TAIL and DONE.

Optional Feature:
- Macro: IO_TX_STAT_EN.
- When defined:
  - Adds a 32-bit sent-byte counter, incremented on each FIFO pop (excluding the TAIL 0x00), reset to 0.
  - Reads of 0x30008–0x3000B return its bytes 0–3, with a snapshot taken on the 0x30008 read (same rules as the cycle counter).
- When undefined: those addresses read 8'h00 and no counter logic exists.

Test Plan:
- Reset, `tx_ready`=1; write 0x41 then 0x42 to 0x30000 → `tx_data` 0x41 then 0x42 on consecutive accepted cycles, `overflow`=0.
- `tx_ready`=0; write 12 nonzero bytes → `io_buffer_full` rises the cycle after the 12th push. Write 5 more → the 17th write is dropped and `overflow`=1. Then `tx_ready`=1 → exactly 16 bytes emerge, in order.
- Write 0x00 to 0x30000 → no push, `tx_valid` stays 0.
- After 100 cycles out of reset, read 0x30004 then 0x30005 → `io_din` = counter[7:0] at the read cycle, then snapshot[15:8]; both bytes come from the same snapshot.
- Push 3 bytes with `tx_ready`=0, write 0x30004, raise `tx_ready` → 3 bytes, then 0x00, then `program_done`=1; a later 0x30000 write produces no TX.
- Assert `rst_in` during DRAIN with 2 bytes queued → next cycle `tx_valid`=0, `program_done`=0, state RUN, counter restarts at 0.
